uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Parametrised next-generation UART transmitter.
- Buffers parallel words from the test/host side in an internal FIFO, then serialises them LSB-first with start, optional parity and 1 or 2 stop bits.
- Supports a programmable bit period and configurable data width.
- Replaces the fixed 8-bit, one-clock-per-bit TX in the UART TX/RX pair; its serial output feeds the existing receiver unchanged when DATA_WIDTH=8 and CLKS_PER_BIT=1.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (5..9).
- CLKS_PER_BIT, 1, clock cycles per serial bit (>=1).
- STOP_BITS, 1, stop bits per frame (1 or 2).
- FIFO_DEPTH, 4, words buffered (power of two, >=2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  parallel word to transmit.
- DATA_VALID  input  1  push request; P_DATA is written when DATA_VALID=1 and FIFO_FULL=0.
- PAR_EN  input  1  parity bit enable, sampled per frame at pop.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled per frame at pop.
- TX_OUT  output  1  serial line, idle high.
- Busy  output  1  high while a frame is on the line.
- FIFO_FULL  output  1  FIFO holds FIFO_DEPTH words.
- FIFO_COUNT  output  $clog2(FIFO_DEPTH+1)  words currently buffered.

Behaviour:
- Reset (synchronous): on a clk edge with reset=1:
  - TX_OUT=1, Busy=0, FIFO_FULL=0, FIFO_COUNT=0.
  - FSM returns to IDLE; FIFO pointers are cleared and contents discarded.
  - Reset mid-frame aborts the frame; TX_OUT is high from the next edge onward.
- Push:
  - At edge k, if DATA_VALID=1 and FIFO_FULL=0 (pre-edge value), the word is stored and FIFO_COUNT increments after edge k.
  - If FIFO_FULL=1, the push is silently dropped, even when a pop occurs at the same edge.
- Simultaneous push and pop (not full): FIFO_COUNT is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
  - IDLE: TX_OUT=1, Busy=0. If FIFO_COUNT>0, the next edge pops the head word into the shift register, latches PAR_EN/PAR_TYP, and enters START.
  - START: TX_OUT=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: outputs bit 0 first, each bit held CLKS_PER_BIT cycles; after bit DATA_WIDTH-1 goes to PARITY if the latched PAR_EN=1, else STOP.
  - PARITY: TX_OUT = ^data when even, ~^data when odd; held CLKS_PER_BIT cycles, then STOP.
  - STOP: TX_OUT=1 for STOP_BITS*CLKS_PER_BIT cycles. At its final cycle:
    - if FIFO non-empty: pop and enter START directly (no idle cycle between frames);
    - else enter IDLE.
- Busy = (state != IDLE); it is asserted on the same edge TX_OUT first goes low.
- Latency: DATA_VALID sampled at edge k into an empty FIFO with the FSM idle → TX_OUT=0 and Busy=1 after edge k+1.
- Frame length in cycles = CLKS_PER_BIT*(1 + DATA_WIDTH + PAR_EN + STOP_BITS).
- Bit timing: a down-counter reloads to CLKS_PER_BIT-1 at each bit boundary. CLKS_PER_BIT=1 yields one bit per cycle.
- Changing PAR_EN/PAR_TYP mid-frame has no effect on the current frame.
- FIFO pointers wrap modulo FIFO_DEPTH; FIFO_COUNT saturates at FIFO_DEPTH by construction (push blocked when full).

Test Plan:
All scenarios use DATA_WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1, FIFO_DEPTH=4 unless stated.
1. Single frame, even parity: push 0xA5 with PAR_EN=1, PAR_TYP=0 → after 1 cycle TX_OUT shows 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1, each bit 4 cycles. Busy high 44 cycles, then TX_OUT=1, Busy=0.
2. Parity variants: push 0xA5 with PAR_TYP=1 → parity bit 1. Push 0xA5 with PAR_EN=0 → no parity bit, frame 40 cycles.
3. Back-to-back and full: push 0x01,0x02,0x03,0x04,0x05 on consecutive cycles (first pop at the 2nd edge) → FIFO_FULL asserts, 0x05 is accepted only if a slot was freed before its edge, otherwise dropped. Frames transmit contiguously with no idle cycle between stop and next start; FIFO_COUNT returns to 0.
4. Overflow drop: while FIFO_FULL=1, push 0xFF → FIFO_COUNT unchanged, 0xFF never appears on TX_OUT.
5. Reset mid-frame: assert reset during DATA bit 3 of 0x3C with 2 words queued → next edge TX_OUT=1, Busy=0, FIFO_COUNT=0. Nothing further is transmitted after reset is released.
6. Parameter corner: CLKS_PER_BIT=1, STOP_BITS=2, DATA_WIDTH=5, PAR_EN=0; push 0x13 → TX_OUT sequence 0,1,1,0,0,1,1,1 over 8 cycles. The existing receiver (DATA_WIDTH=8 instance with CLKS_PER_BIT=1) decodes 0x5A correctly when driven from an 8-bit configuration.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Host-side bus of the buffered UART transmitter: the parallel word push
// handshake, the per-frame parity controls, and the serial/status outputs.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;
  logic                  FIFO_FULL;
  logic [CNT_W-1:0]      FIFO_COUNT;

  // Host side: supplies words and parity settings, observes line and status.
  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy, FIFO_FULL, FIFO_COUNT
  );

  // Transmitter side.
  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output TX_OUT, Busy, FIFO_FULL, FIFO_COUNT
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter. Words pushed by the host are queued in a small
// FIFO and sent LSB-first as start / data / optional parity / stop bits, each
// bit held CLKS_PER_BIT cycles. Frames leave back to back while the FIFO has
// data: the last stop cycle pops the next word straight into START.
module uart_tx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);

  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int STOP_TICKS = STOP_BITS * CLKS_PER_BIT;
  localparam int TICK_W     = (STOP_TICKS > 1) ? $clog2(STOP_TICKS) : 1;

  localparam logic [TICK_W-1:0] BIT_RELOAD  = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] STOP_RELOAD = TICK_W'(STOP_TICKS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and control
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_full;

  // Serialiser state
  state_t                r_state;
  logic [TICK_W-1:0]     r_tick;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_bit;
  logic                  r_par_en;
  logic                  r_tx;
  logic                  r_busy;

  // Next-state values
  state_t                w_state_nx;
  logic [TICK_W-1:0]     w_tick_nx;
  logic [BIT_W-1:0]      w_bit_nx;
  logic [DATA_WIDTH-1:0] w_shift_nx;
  logic                  w_par_bit_nx;
  logic                  w_par_en_nx;
  logic                  w_tx_nx;
  logic                  w_busy_nx;
  logic                  w_pop;
  logic                  w_push;
  logic [CNT_W-1:0]      w_count_nx;

  // A push is only honoured while the FIFO is not full; a pop at the same
  // edge does not make room for it.
  assign w_push = bus.DATA_VALID & ~r_full;

  // Occupancy bookkeeping: a simultaneous push and pop leaves the count as is.
  always_comb begin
    w_count_nx = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nx = r_count + CNT_W'(1);
      2'b01:   w_count_nx = r_count - CNT_W'(1);
      default: w_count_nx = r_count;
    endcase
  end

  // Frame sequencing: next state, bit timer, shift register and the
  // registered line level/busy that correspond to the next state.
  always_comb begin
    w_state_nx   = r_state;
    w_tick_nx    = (r_tick == '0) ? '0 : r_tick - TICK_W'(1);
    w_bit_nx     = r_bit;
    w_shift_nx   = r_shift;
    w_par_bit_nx = r_par_bit;
    w_par_en_nx  = r_par_en;
    w_pop        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (r_count != '0) w_pop = 1'b1;
      end
      S_START: begin
        if (r_tick == '0) begin
          w_state_nx = S_DATA;
          w_tick_nx  = BIT_RELOAD;
          w_bit_nx   = '0;
        end
      end
      S_DATA: begin
        if (r_tick == '0) begin
          w_tick_nx = BIT_RELOAD;
          if (r_bit == LAST_BIT) begin
            if (r_par_en) begin
              w_state_nx = S_PARITY;
            end else begin
              w_state_nx = S_STOP;
              w_tick_nx  = STOP_RELOAD;
            end
          end else begin
            w_bit_nx   = r_bit + BIT_W'(1);
            w_shift_nx = r_shift >> 1;
          end
        end
      end
      S_PARITY: begin
        if (r_tick == '0) begin
          w_state_nx = S_STOP;
          w_tick_nx  = STOP_RELOAD;
        end
      end
      S_STOP: begin
        if (r_tick == '0) begin
          if (r_count != '0) w_pop = 1'b1;
          else               w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    // Popping loads the head word and freezes this frame's parity settings.
    if (w_pop) begin
      w_state_nx   = S_START;
      w_tick_nx    = BIT_RELOAD;
      w_shift_nx   = r_mem[r_rd_ptr];
      w_par_bit_nx = (^r_mem[r_rd_ptr]) ^ bus.PAR_TYP;
      w_par_en_nx  = bus.PAR_EN;
    end

    unique case (w_state_nx)
      S_START:  w_tx_nx = 1'b0;
      S_DATA:   w_tx_nx = w_shift_nx[0];
      S_PARITY: w_tx_nx = w_par_bit_nx;
      default:  w_tx_nx = 1'b1;
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
  end

  // Control registers: FSM, timers, FIFO pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_tick   <= '0;
      r_bit    <= '0;
      r_par_en <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_tick   <= w_tick_nx;
      r_bit    <= w_bit_nx;
      r_par_en <= w_par_en_nx;
      r_tx     <= w_tx_nx;
      r_busy   <= w_busy_nx;
      r_count  <= w_count_nx;
      r_full   <= (w_count_nx == DEPTH_CNT);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Data path registers carry no reset; pointers and state qualify them.
  always_ff @(posedge clk) begin
    r_shift   <= w_shift_nx;
    r_par_bit <= w_par_bit_nx;
    if (w_push) r_mem[r_wr_ptr] <= bus.P_DATA;
  end

  assign bus.TX_OUT     = r_tx;
  assign bus.Busy       = r_busy;
  assign bus.FIFO_FULL  = r_full;
  assign bus.FIFO_COUNT = r_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a main instance (8 bits, 4 clocks/bit, 1 stop,
// depth 4) checked cycle by cycle against a frame-level reference model, plus
// a 5-bit/1-clock/2-stop corner instance and an 8-bit/1-clock instance read by
// a simple behavioural receiver.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) ifa ();
  uart_tx_fifo_if #(.DATA_WIDTH(5), .FIFO_DEPTH(4)) ifb ();
  uart_tx_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) ifc ();

  uart_tx_fifo #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.clk(clk), .reset(rst), .bus(ifa));
  uart_tx_fifo #(.DATA_WIDTH(5), .CLKS_PER_BIT(1), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_b (.clk(clk), .reset(rst), .bus(ifb));
  uart_tx_fifo #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_c (.clk(clk), .reset(rst), .bus(ifc));

  // Reference model for dut_a: a queue of buffered words and a queue holding
  // the remaining per-cycle line levels of the frame currently on the wire.
  logic [7:0] mq[$];
  bit         ml[$];
  logic       m_tx    = 1'b1;
  logic       m_busy  = 1'b0;
  logic       m_full  = 1'b0;
  logic [2:0] m_count = 3'd0;

  always @(posedge clk) begin : ref_model
    bit         pre_full;
    bit         pre_nonempty;
    bit         do_push;
    logic [7:0] w;
    if (rst) begin
      mq.delete();
      ml.delete();
    end else begin
      pre_full     = (mq.size() == 4);
      pre_nonempty = (mq.size() > 0);
      do_push      = ifa.DATA_VALID && !pre_full;
      if (ml.size() > 0) void'(ml.pop_front());
      if (ml.size() == 0 && pre_nonempty) begin
        w = mq.pop_front();
        repeat (4) ml.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (4) ml.push_back(w[i]);
        if (ifa.PAR_EN) repeat (4) ml.push_back((^w) ^ ifa.PAR_TYP);
        repeat (4) ml.push_back(1'b1);
      end
      if (do_push) mq.push_back(ifa.P_DATA);
    end
    m_tx    = (ml.size() > 0) ? ml[0] : 1'b1;
    m_busy  = (ml.size() > 0);
    m_count = 3'(mq.size());
    m_full  = (mq.size() == 4);
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ifa.TX_OUT !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", ifa.TX_OUT); end
    n_checks++;
    if (ifa.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", ifa.Busy); end
    n_checks++;
    if (ifa.FIFO_FULL !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", ifa.FIFO_FULL); end
    n_checks++;
    if (ifa.FIFO_COUNT !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", ifa.FIFO_COUNT); end
    n_checks++;
    if ({ifb.TX_OUT, ifb.Busy, ifc.TX_OUT, ifc.Busy} !== 4'b1010) begin
      n_fail++; $display("FAIL reset_corner got %b%b%b%b want 1010", ifb.TX_OUT, ifb.Busy, ifc.TX_OUT, ifc.Busy);
    end
    rst = 1'b0;
  endtask

  // One 0xA5 frame; exp_len is the busy duration, exp_b37 the line level in
  // the parity slot (busy cycles 36..39), which is the stop bit when disabled.
  task automatic test_frame_parity(input logic pe, input logic pt, input int exp_len,
                                   input logic exp_b37, input string name);
    int   busy_cnt = 0;
    logic seen37   = 1'bx;
    ifa.PAR_EN = pe; ifa.PAR_TYP = pt; ifa.P_DATA = 8'hA5; ifa.DATA_VALID = 1'b1;
    for (int c = 0; c < 62; c++) begin
      @(negedge clk);
      if (c == 0) ifa.DATA_VALID = 1'b0;
      n_checks++;
      if ({ifa.TX_OUT, ifa.Busy, ifa.FIFO_FULL, ifa.FIFO_COUNT} !== {m_tx, m_busy, m_full, m_count}) begin
        n_fail++;
        $display("FAIL %s cycle %0d got tx/busy/full/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", name, c,
                 ifa.TX_OUT, ifa.Busy, ifa.FIFO_FULL, ifa.FIFO_COUNT, m_tx, m_busy, m_full, m_count);
      end
      if (ifa.Busy === 1'b1) begin
        if (busy_cnt == 37) seen37 = ifa.TX_OUT;
        busy_cnt++;
      end
      if (c == 1) begin
        n_checks++;
        if ({ifa.TX_OUT, ifa.Busy} !== 2'b01) begin
          n_fail++; $display("FAIL %s_latency got tx/busy=%b/%b want 0/1", name, ifa.TX_OUT, ifa.Busy);
        end
      end
    end
    n_checks++;
    if (busy_cnt != exp_len) begin n_fail++; $display("FAIL %s_len got %0d want %0d", name, busy_cnt, exp_len); end
    n_checks++;
    if (seen37 !== exp_b37) begin n_fail++; $display("FAIL %s_parity_slot got %b want %b", name, seen37, exp_b37); end
  endtask

  task automatic test_back_to_back();
    bit full_seen = 0;
    int run = 0, best_run = 0;
    ifa.PAR_EN = 1'b0; ifa.PAR_TYP = 1'b0;
    for (int c = 0; c < 230; c++) begin
      if (c < 5) begin ifa.DATA_VALID = 1'b1; ifa.P_DATA = 8'(c + 1); end
      else ifa.DATA_VALID = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({ifa.TX_OUT, ifa.Busy, ifa.FIFO_FULL, ifa.FIFO_COUNT} !== {m_tx, m_busy, m_full, m_count}) begin
        n_fail++;
        $display("FAIL b2b cycle %0d got tx/busy/full/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", c,
                 ifa.TX_OUT, ifa.Busy, ifa.FIFO_FULL, ifa.FIFO_COUNT, m_tx, m_busy, m_full, m_count);
      end
      if (ifa.FIFO_FULL === 1'b1) full_seen = 1;
      if (ifa.Busy === 1'b1) run++; else run = 0;
      if (run > best_run) best_run = run;
    end
    ifa.DATA_VALID = 1'b0;
    n_checks++;
    if (!full_seen) begin n_fail++; $display("FAIL b2b_full got 0 want 1"); end
    n_checks++;
    if (best_run != 200) begin n_fail++; $display("FAIL b2b_contiguous got %0d want 200", best_run); end
    n_checks++;
    if (ifa.FIFO_COUNT !== 3'd0) begin n_fail++; $display("FAIL b2b_drain got %0d want 0", ifa.FIFO_COUNT); end
  endtask

  task automatic test_overflow();
    ifa.PAR_EN = 1'b0;
    for (int c = 0; c < 240; c++) begin
      if (c < 5)      begin ifa.DATA_VALID = 1'b1; ifa.P_DATA = 8'h11 * 8'(c + 1); end
      else if (c < 8) begin ifa.DATA_VALID = 1'b1; ifa.P_DATA = 8'hFF; end
      else            ifa.DATA_VALID = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({ifa.TX_OUT, ifa.Busy, ifa.FIFO_FULL, ifa.FIFO_COUNT} !== {m_tx, m_busy, m_full, m_count}) begin
        n_fail++;
        $display("FAIL ovf cycle %0d got tx/busy/full/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", c,
                 ifa.TX_OUT, ifa.Busy, ifa.FIFO_FULL, ifa.FIFO_COUNT, m_tx, m_busy, m_full, m_count);
      end
      if (c >= 4 && c <= 7) begin
        n_checks++;
        if ({ifa.FIFO_FULL, ifa.FIFO_COUNT} !== {1'b1, 3'd4}) begin
          n_fail++; $display("FAIL ovf_hold cycle %0d got full/cnt=%b/%0d want 1/4", c, ifa.FIFO_FULL, ifa.FIFO_COUNT);
        end
      end
    end
    ifa.DATA_VALID = 1'b0;
  endtask

  task automatic test_random();
    int guard = 0;
    for (int c = 0; c < 1500; c++) begin
      ifa.DATA_VALID = ($urandom_range(0, 3) == 0);
      ifa.P_DATA     = 8'($urandom);
      ifa.PAR_EN     = 1'($urandom);
      ifa.PAR_TYP    = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if ({ifa.TX_OUT, ifa.Busy, ifa.FIFO_FULL, ifa.FIFO_COUNT} !== {m_tx, m_busy, m_full, m_count}) begin
        n_fail++;
        $display("FAIL rand cycle %0d got tx/busy/full/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", c,
                 ifa.TX_OUT, ifa.Busy, ifa.FIFO_FULL, ifa.FIFO_COUNT, m_tx, m_busy, m_full, m_count);
      end
    end
    ifa.DATA_VALID = 1'b0;
    while ((m_busy || m_count != 0) && guard < 400) begin
      @(negedge clk);
      guard++;
      n_checks++;
      if ({ifa.TX_OUT, ifa.Busy, ifa.FIFO_FULL, ifa.FIFO_COUNT} !== {m_tx, m_busy, m_full, m_count}) begin
        n_fail++;
        $display("FAIL rand_drain cycle %0d got tx/busy/full/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", guard,
                 ifa.TX_OUT, ifa.Busy, ifa.FIFO_FULL, ifa.FIFO_COUNT, m_tx, m_busy, m_full, m_count);
      end
    end
    n_checks++;
    if (guard >= 400) begin n_fail++; $display("FAIL rand_drain_timeout got %0d cycles want <400", guard); end
  endtask

  task automatic test_reset_mid_frame();
    ifa.PAR_EN = 1'b1; ifa.PAR_TYP = 1'b0;
    ifa.DATA_VALID = 1'b1; ifa.P_DATA = 8'h3C;
    @(negedge clk); ifa.P_DATA = 8'h11;
    @(negedge clk); ifa.P_DATA = 8'h22;
    @(negedge clk); ifa.DATA_VALID = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      n_checks++;
      if ({ifa.TX_OUT, ifa.Busy, ifa.FIFO_FULL, ifa.FIFO_COUNT} !== {m_tx, m_busy, m_full, m_count}) begin
        n_fail++;
        $display("FAIL midrst cycle %0d got tx/busy/full/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", c,
                 ifa.TX_OUT, ifa.Busy, ifa.FIFO_FULL, ifa.FIFO_COUNT, m_tx, m_busy, m_full, m_count);
      end
    end
    // Now in data bit 3 of 0x3C (a one) with two words still queued.
    n_checks++;
    if ({ifa.TX_OUT, ifa.Busy, ifa.FIFO_COUNT} !== {1'b1, 1'b1, 3'd2}) begin
      n_fail++; $display("FAIL midrst_pre got tx/busy/cnt=%b/%b/%0d want 1/1/2", ifa.TX_OUT, ifa.Busy, ifa.FIFO_COUNT);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ifa.TX_OUT, ifa.Busy, ifa.FIFO_FULL, ifa.FIFO_COUNT} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      n_fail++; $display("FAIL midrst_post got tx/busy/full/cnt=%b/%b/%b/%0d want 1/0/0/0",
                         ifa.TX_OUT, ifa.Busy, ifa.FIFO_FULL, ifa.FIFO_COUNT);
    end
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n_checks++;
      if ({ifa.TX_OUT, ifa.Busy, ifa.FIFO_COUNT} !== {1'b1, 1'b0, 3'd0}) begin
        n_fail++; $display("FAIL midrst_quiet cycle %0d got tx/busy/cnt=%b/%b/%0d want 1/0/0",
                           c, ifa.TX_OUT, ifa.Busy, ifa.FIFO_COUNT);
      end
    end
  endtask

  task automatic test_corner();
    bit exp_seq[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    ifb.PAR_EN = 1'b0; ifb.P_DATA = 5'h13; ifb.DATA_VALID = 1'b1;
    @(negedge clk); ifb.DATA_VALID = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      n_checks++;
      if (c < 8) begin
        if ({ifb.TX_OUT, ifb.Busy} !== {exp_seq[c], 1'b1}) begin
          n_fail++; $display("FAIL corner bit %0d got tx/busy=%b/%b want %b/1", c, ifb.TX_OUT, ifb.Busy, exp_seq[c]);
        end
      end else if ({ifb.TX_OUT, ifb.Busy} !== 2'b10) begin
        n_fail++; $display("FAIL corner_end got tx/busy=%b/%b want 1/0", ifb.TX_OUT, ifb.Busy);
      end
    end
  endtask

  task automatic test_rx_compat();
    logic [7:0] rx = '0;
    int         waited = 0;
    ifc.PAR_EN = 1'b0; ifc.P_DATA = 8'h5A; ifc.DATA_VALID = 1'b1;
    @(negedge clk); ifc.DATA_VALID = 1'b0;
    while (ifc.TX_OUT !== 1'b0 && waited < 20) begin @(negedge clk); waited++; end
    n_checks++;
    if (waited >= 20) begin
      n_fail++; $display("FAIL rx_start_timeout got no start bit want start within 20 cycles");
    end else begin
      for (int i = 0; i < 8; i++) begin @(negedge clk); rx[i] = ifc.TX_OUT; end
      @(negedge clk);
      n_checks++;
      if (rx !== 8'h5A) begin n_fail++; $display("FAIL rx_byte got %h want 5a", rx); end
      n_checks++;
      if (ifc.TX_OUT !== 1'b1) begin n_fail++; $display("FAIL rx_stop got %b want 1", ifc.TX_OUT); end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    ifa.P_DATA = '0; ifa.DATA_VALID = 1'b0; ifa.PAR_EN = 1'b0; ifa.PAR_TYP = 1'b0;
    ifb.P_DATA = '0; ifb.DATA_VALID = 1'b0; ifb.PAR_EN = 1'b0; ifb.PAR_TYP = 1'b0;
    ifc.P_DATA = '0; ifc.DATA_VALID = 1'b0; ifc.PAR_EN = 1'b0; ifc.PAR_TYP = 1'b0;
    test_reset();
    @(negedge clk);
    test_frame_parity(1'b1, 1'b0, 44, 1'b0, "even");
    test_frame_parity(1'b1, 1'b1, 44, 1'b1, "odd");
    test_frame_parity(1'b0, 1'b0, 40, 1'b1, "nopar");
    test_back_to_back();
    test_overflow();
    test_random();
    test_reset_mid_frame();
    test_corner();
    test_rx_compat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
